// File: rtl/ro_arbiter.sv
// Round-robin readout arbiter.
// Grants one triggered channel at a time, writes a header word
// {1'b1, chan, bc} to the output FIFO, then reads how_many samples from the
// channel (one-cycle read latency) and writes each as {4'b0000, sample}.
// A one-cycle ch_done pulse closes each service.
//
// Ports:
//   CLK, RST     - clock, synchronous active-high reset
//   pending      - per-channel data-ready levels
//   how_many     - samples per service (latched at grant)
//   bc           - bunch counter (latched at grant)
//   ch_data      - packed channel samples, channel i at [i*WIDTH +: WIDTH]
//   fifo_afull   - output FIFO almost full (at most one free slot)
//   ch_rd_req    - one-hot read strobe to the granted channel
//   ch_done      - one-hot service-complete pulse
//   fifo_wr_en   - output FIFO write strobe
//   fifo_din     - output FIFO write data, holds when not writing
//   busy         - high whenever not idle
//   cur_chan     - granted channel index
module ro_arbiter #(
    parameter int unsigned CHAN  = 8,
    parameter int unsigned SIZE  = 8,
    parameter int unsigned WIDTH = 12
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [CHAN-1:0]       pending,
    input  logic [SIZE-1:0]       how_many,
    input  logic [11:0]           bc,
    input  logic [WIDTH*CHAN-1:0] ch_data,
    input  logic                  fifo_afull,
    output logic [CHAN-1:0]       ch_rd_req,
    output logic [CHAN-1:0]       ch_done,
    output logic                  fifo_wr_en,
    output logic [WIDTH+3:0]      fifo_din,
    output logic                  busy,
    output logic [2:0]            cur_chan
);

    typedef enum logic [2:0] {
        StIdle,
        StHdr,
        StRd,
        StWait,
        StDone
    } state_e;

    state_e            state_q;
    logic [2:0]        cur_chan_q;
    logic [2:0]        last_grant_q;
    logic [11:0]       bc_q;
    logic [SIZE-1:0]   how_many_q;
    logic [SIZE-1:0]   word_cnt_q;
    logic [CHAN-1:0]   ch_rd_req_q;
    logic [CHAN-1:0]   ch_done_q;
    logic              fifo_wr_en_q;
    logic [WIDTH+3:0]  fifo_din_q;

    logic              grant_valid;
    logic [2:0]        grant_idx;
    logic [2:0]        cand;
    logic [SIZE-1:0]   word_cnt_inc;
    logic [CHAN-1:0]   cur_onehot;
    logic [WIDTH-1:0]  cur_sample;

    // Round-robin search: start just after the last grant, last grant checked last.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = 3'd0;
        cand        = 3'd0;
        for (int i = 1; i <= CHAN; i++) begin
            cand = last_grant_q + 3'(i);
            if (!grant_valid && pending[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    assign word_cnt_inc = word_cnt_q + {{(SIZE-1){1'b0}}, 1'b1};
    assign cur_onehot   = {{(CHAN-1){1'b0}}, 1'b1} << cur_chan_q;
    assign cur_sample   = ch_data[int'(cur_chan_q) * WIDTH +: WIDTH];

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= StIdle;
            cur_chan_q   <= 3'd0;
            last_grant_q <= 3'd7;
            bc_q         <= 12'd0;
            how_many_q   <= '0;
            word_cnt_q   <= '0;
            ch_rd_req_q  <= '0;
            ch_done_q    <= '0;
            fifo_wr_en_q <= 1'b0;
            fifo_din_q   <= '0;
        end else begin
            ch_rd_req_q  <= '0;
            ch_done_q    <= '0;
            fifo_wr_en_q <= 1'b0;

            // The sample requested last cycle is on ch_data now; write it
            // regardless of afull since the slot was reserved at request time.
            if (ch_rd_req_q != '0) begin
                fifo_wr_en_q <= 1'b1;
                fifo_din_q   <= {4'b0000, cur_sample};
            end

            unique case (state_q)
                StIdle: begin
                    if (grant_valid) begin
                        cur_chan_q <= grant_idx;
                        bc_q       <= bc;
                        how_many_q <= how_many;
                        word_cnt_q <= '0;
                        state_q    <= StHdr;
                    end
                end
                StHdr: begin
                    if (!fifo_afull) begin
                        fifo_wr_en_q <= 1'b1;
                        fifo_din_q   <= {1'b1, cur_chan_q, bc_q};
                        state_q      <= (how_many_q == '0) ? StDone : StRd;
                    end
                end
                StRd: begin
                    if (!fifo_afull) begin
                        ch_rd_req_q <= cur_onehot;
                        word_cnt_q  <= word_cnt_inc;
                        if (word_cnt_inc == how_many_q) begin
                            state_q <= StWait;
                        end
                    end
                end
                StWait: begin
                    state_q <= StDone;
                end
                StDone: begin
                    ch_done_q    <= cur_onehot;
                    last_grant_q <= cur_chan_q;
                    word_cnt_q   <= '0;
                    state_q      <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign ch_rd_req  = ch_rd_req_q;
    assign ch_done    = ch_done_q;
    assign fifo_wr_en = fifo_wr_en_q;
    assign fifo_din   = fifo_din_q;
    assign cur_chan   = cur_chan_q;
    assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_ro_arbiter.sv
// Self-checking bench for ro_arbiter: scoreboard of expected FIFO words and
// service-complete pulses, filled when a service is stimulated and drained
// as the DUT writes.
module tb_ro_arbiter;

    localparam int CHAN  = 8;
    localparam int SIZE  = 8;
    localparam int WIDTH = 12;

    logic                  CLK = 1'b0;
    logic                  RST;
    logic [CHAN-1:0]       pending;
    logic [SIZE-1:0]       how_many;
    logic [11:0]           bc;
    logic [WIDTH*CHAN-1:0] ch_data;
    logic                  fifo_afull;
    logic [CHAN-1:0]       ch_rd_req;
    logic [CHAN-1:0]       ch_done;
    logic                  fifo_wr_en;
    logic [WIDTH+3:0]      fifo_din;
    logic                  busy;
    logic [2:0]            cur_chan;

    ro_arbiter #(
        .CHAN  (CHAN),
        .SIZE  (SIZE),
        .WIDTH (WIDTH)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .pending    (pending),
        .how_many   (how_many),
        .bc         (bc),
        .ch_data    (ch_data),
        .fifo_afull (fifo_afull),
        .ch_rd_req  (ch_rd_req),
        .ch_done    (ch_done),
        .fifo_wr_en (fifo_wr_en),
        .fifo_din   (fifo_din),
        .busy       (busy),
        .cur_chan   (cur_chan)
    );

    always #5 CLK = ~CLK;

    // Channel model: each channel presents {chan, 0, seq} and advances on a read.
    logic [7:0] seq [CHAN] = '{default: 8'h00};

    always_comb begin
        ch_data = '0;
        for (int i = 0; i < CHAN; i++) begin
            ch_data[i*WIDTH +: WIDTH] = {3'(i), 1'b0, seq[i]};
        end
    end

    always @(posedge CLK) begin
        for (int i = 0; i < CHAN; i++) begin
            if (ch_rd_req[i]) seq[i] <= seq[i] + 8'd1;
        end
    end

    int n_checks = 0;
    int n_fail   = 0;
    int n_rd     = 0;
    int n_done   = 0;
    int svc_writes;
    logic prev_afull;

    logic [15:0] exp_q[$];
    int          done_chan_q[$];
    int          done_wr_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Expect a header, n samples and optionally the done pulse for channel c.
    task automatic push_svc(input int c, input int n, input logic [11:0] b, input bit with_done);
        logic [2:0] c3;
        logic [7:0] s;
        c3 = 3'(c);
        s  = seq[c];
        exp_q.push_back({1'b1, c3, b});
        for (int k = 0; k < n; k++) begin
            exp_q.push_back({4'b0000, c3, 1'b0, s});
            s = s + 8'd1;
        end
        if (with_done) begin
            done_chan_q.push_back(c);
            done_wr_q.push_back(n + 1);
        end
    endtask

    task automatic wait_busy();
        int t = 0;
        while (!busy && t < 200) begin
            tick();
            t++;
        end
        check_eq("busy_timeout", 32'(busy), 1);
    endtask

    task automatic wait_done(input int target, input int budget);
        int t = 0;
        while (n_done < target && t < budget) begin
            tick();
            t++;
        end
        check_eq("done_timeout", n_done, target);
    endtask

    // Returns in the cycle where the k-th read strobe is visible.
    task automatic wait_rd_local(input int k);
        int cnt = 0;
        int t   = 0;
        while (cnt < k && t < 200) begin
            tick();
            t++;
            if (ch_rd_req != '0) cnt++;
        end
        check_eq("rd_timeout", cnt, k);
    endtask

    task automatic do_reset();
        RST = 1'b1;
        tick();
        tick();
        RST = 1'b0;
    endtask

    // Output monitor, sampled mid-cycle.
    initial begin
        prev_afull = 1'b0;
        svc_writes = 0;
        forever begin
            @(negedge CLK);
            if (ch_rd_req != '0) begin
                n_rd++;
                check_eq("rd_onehot", $countones(ch_rd_req), 1);
                check_eq("rd_chan", 32'(ch_rd_req), 32'(8'b1 << cur_chan));
                check_eq("rd_after_afull", 32'(prev_afull), 0);
            end
            if (fifo_wr_en) begin
                svc_writes++;
                if (exp_q.size() == 0) begin
                    check_eq("wr_extra", 32'(fifo_din), 32'hFFFF_FFFF);
                end else begin
                    check_eq("fifo_din", 32'(fifo_din), 32'(exp_q.pop_front()));
                end
            end
            if (ch_done != '0) begin
                n_done++;
                check_eq("done_onehot", $countones(ch_done), 1);
                if (done_chan_q.size() == 0) begin
                    check_eq("done_extra", 32'(ch_done), 0);
                end else begin
                    check_eq("done_chan", 32'(ch_done), 32'(8'b1 << done_chan_q.pop_front()));
                    check_eq("done_writes", svc_writes, done_wr_q.pop_front());
                end
                svc_writes = 0;
            end
            if (RST) svc_writes = 0;
            prev_afull = fifo_afull;
        end
    end

    initial begin
        #200us;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int nd;
        int rd0;
        RST        = 1'b1;
        pending    = '0;
        how_many   = '0;
        bc         = '0;
        fifo_afull = 1'b0;
        tick();
        tick();
        tick();

        // Reset state.
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_rd_req", 32'(ch_rd_req), 0);
        check_eq("rst_done", 32'(ch_done), 0);
        check_eq("rst_wr_en", 32'(fifo_wr_en), 0);
        check_eq("rst_din", 32'(fifo_din), 0);
        check_eq("rst_chan", 32'(cur_chan), 0);
        RST = 1'b0;

        // Single channel 0, three samples; later bc/how_many changes are ignored.
        push_svc(0, 3, 12'h0A5, 1'b1);
        pending  = 8'h01;
        how_many = 8'd3;
        bc       = 12'h0A5;
        wait_busy();
        pending  = 8'h00;
        bc       = 12'hFFF;
        how_many = 8'd7;
        wait_done(1, 100);
        tick();
        check_eq("din_hold", 32'(fifo_din), 32'h0002);

        // All channels pending: grant order 0..7 after reset.
        do_reset();
        nd       = n_done;
        bc       = 12'h123;
        how_many = 8'd1;
        for (int c = 0; c < CHAN; c++) push_svc(c, 1, 12'h123, 1'b1);
        pending = 8'hFF;
        begin
            int t = 0;
            while (!(busy && cur_chan == 3'd7) && t < 300) begin
                tick();
                t++;
            end
        end
        pending = 8'h00;
        wait_done(nd + 8, 300);

        // Zero-length service on channel 4.
        nd  = n_done;
        rd0 = n_rd;
        push_svc(4, 0, 12'h3C4, 1'b1);
        how_many = 8'd0;
        bc       = 12'h3C4;
        pending  = 8'h10;
        wait_busy();
        pending = 8'h00;
        wait_done(nd + 1, 100);
        check_eq("hm0_no_rd", n_rd, rd0);

        // Back-pressure for 5 cycles after the second read of four.
        nd = n_done;
        push_svc(1, 4, 12'h0B1, 1'b1);
        how_many = 8'd4;
        bc       = 12'h0B1;
        pending  = 8'h02;
        wait_busy();
        pending = 8'h00;
        wait_rd_local(2);
        fifo_afull = 1'b1;
        repeat (5) tick();
        fifo_afull = 1'b0;
        wait_done(nd + 1, 100);

        // Reset in the middle of a six-word service on channel 2.
        nd = n_done;
        push_svc(2, 1, 12'h222, 1'b0);
        how_many = 8'd6;
        bc       = 12'h222;
        pending  = 8'h04;
        wait_busy();
        pending = 8'h00;
        wait_rd_local(2);
        RST = 1'b1;
        tick();
        check_eq("mid_rst_busy", 32'(busy), 0);
        check_eq("mid_rst_rd_req", 32'(ch_rd_req), 0);
        check_eq("mid_rst_done", 32'(ch_done), 0);
        check_eq("mid_rst_wr_en", 32'(fifo_wr_en), 0);
        check_eq("mid_rst_din", 32'(fifo_din), 0);
        check_eq("mid_rst_chan", 32'(cur_chan), 0);
        RST = 1'b0;
        push_svc(0, 1, 12'h050, 1'b1);
        how_many = 8'd1;
        bc       = 12'h050;
        pending  = 8'h05;
        wait_busy();
        check_eq("post_rst_grant", 32'(cur_chan), 0);
        pending = 8'h00;
        wait_done(nd + 1, 100);
        check_eq("no_done_abort", n_done, nd + 1);

        // Pending changes mid-service: 3 finishes, then 5 is granted.
        nd = n_done;
        push_svc(3, 3, 12'h333, 1'b1);
        push_svc(5, 2, 12'h555, 1'b1);
        how_many = 8'd3;
        bc       = 12'h333;
        pending  = 8'h08;
        wait_busy();
        check_eq("grant_ch3", 32'(cur_chan), 3);
        pending  = 8'h20;
        how_many = 8'd2;
        bc       = 12'h555;
        wait_done(nd + 1, 100);
        tick();
        check_eq("grant_ch5", 32'(cur_chan), 5);
        pending = 8'h00;
        wait_done(nd + 2, 100);

        // Maximum count: 255 data words on channel 6.
        nd = n_done;
        push_svc(6, 255, 12'h6FF, 1'b1);
        how_many = 8'd255;
        bc       = 12'h6FF;
        pending  = 8'h40;
        wait_busy();
        pending = 8'h00;
        wait_done(nd + 1, 1000);

        repeat (4) tick();
        check_eq("sb_empty", 32'(exp_q.size()), 0);
        check_eq("done_q_empty", 32'(done_chan_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
